// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared constants for the programmable clock divider and its users.
//   CLKDIV_WIDTH        default width of the counter and divide value
//   CLKDIV_DEFAULT_DIV  default terminal count loaded at reset
//   DIV_1HZ             10 MHz system clock: tick at 2 Hz, divided_clk at 1 Hz
//   DIV_SCAN_1KHZ       10 MHz system clock: 1 kHz display-mux scan tick
// -----------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int unsigned CLKDIV_WIDTH       = 32;
  localparam int unsigned CLKDIV_DEFAULT_DIV = 100;

  localparam int unsigned DIV_1HZ       = 4_999_999;
  localparam int unsigned DIV_SCAN_1KHZ = 9_999;

endpackage

// File: rtl/clkdiv_shadow_reg.sv
// -----------------------------------------------------------------------------
// clkdiv_shadow_reg
// Holds a newly requested divide value until the counter reaches a safe point.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   load_valid     request to capture div_in
//   div_in         requested terminal count
//   apply          top is consuming the shadow this edge (wrap or sync_clr)
//   load_ready     high when nothing is pending
//   shadow         captured terminal count
//   pending        shadow holds a value not yet applied
// -----------------------------------------------------------------------------
module clkdiv_shadow_reg
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH = CLKDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] div_in,
  input  logic             apply,
  output logic             load_ready,
  output logic [WIDTH-1:0] shadow,
  output logic             pending
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;

  // A load is only accepted while nothing is pending, and apply only happens
  // while something is pending, so the two can never collide on one edge.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (load_valid && !pending_q) begin
      shadow_d  = div_in;
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign load_ready = ~pending_q;
  assign shadow     = shadow_q;
  assign pending    = pending_q;

endmodule

// File: rtl/programmable_clock_divider.sv
// -----------------------------------------------------------------------------
// programmable_clock_divider
// Runtime-programmable timebase: tick pulses once every D+1 enabled cycles and
// divided_clk toggles on the same wraps (period 2*(D+1)). A new D is loaded
// through a valid/ready handshake and takes effect at the next wrap, or
// immediately on sync_clr.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   en             count enable; low freezes counter and outputs
//   sync_clr       synchronous phase restart
//   div_in         new terminal count, captured when load_valid && load_ready
//   load_valid     load request
//   load_ready     high when no load is pending
//   div_active     terminal count currently in use
//   divided_clk    50%-duty divided output
//   tick           one-cycle strobe per wrap
// Optional (macro CLKDIV_STATUS_EN):
//   cnt_out        live counter value
//   wrap_count     16-bit wrap counter, cleared by reset and sync_clr
// -----------------------------------------------------------------------------
module programmable_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH       = CLKDIV_WIDTH,
  parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] div_active,
  output logic             divided_clk,
  output logic             tick
`ifdef CLKDIV_STATUS_EN
  ,
  output logic [WIDTH-1:0] cnt_out,
  output logic [15:0]      wrap_count
`endif
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic             divided_clk_q, divided_clk_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] shadow;
  logic             pending;
  logic             wrap;
  logic             apply;

  assign wrap  = en && (cnt_q == div_active_q);
  // The shadow is consumed only when the counter is (or is forced) back to
  // zero, so a smaller divisor never leaves cnt above div_active.
  assign apply = pending && (sync_clr || wrap);

  clkdiv_shadow_reg #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .div_in     (div_in),
    .apply      (apply),
    .load_ready (load_ready),
    .shadow     (shadow),
    .pending    (pending)
  );

  // sync_clr outranks counting, even on a cycle that would otherwise wrap.
  always_comb begin
    cnt_d         = cnt_q;
    div_active_d  = div_active_q;
    divided_clk_d = divided_clk_q;
    tick_d        = 1'b0;
    if (sync_clr) begin
      cnt_d         = '0;
      divided_clk_d = 1'b0;
      if (pending) div_active_d = shadow;
    end else if (wrap) begin
      cnt_d         = '0;
      tick_d        = 1'b1;
      divided_clk_d = ~divided_clk_q;
      if (pending) div_active_d = shadow;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      div_active_q  <= WIDTH'(DEFAULT_DIV);
      divided_clk_q <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      div_active_q  <= div_active_d;
      divided_clk_q <= divided_clk_d;
      tick_q        <= tick_d;
    end
  end

  assign div_active  = div_active_q;
  assign divided_clk = divided_clk_q;
  assign tick        = tick_q;

`ifdef CLKDIV_STATUS_EN
  logic [15:0] wrap_count_q, wrap_count_d;

  always_comb begin
    wrap_count_d = wrap_count_q;
    if (sync_clr)  wrap_count_d = '0;
    else if (wrap) wrap_count_d = wrap_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrap_count_q <= '0;
    else          wrap_count_q <= wrap_count_d;
  end

  assign cnt_out    = cnt_q;
  assign wrap_count = wrap_count_q;
`endif

endmodule

// File: tb/tb_programmable_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_programmable_clock_divider
// Directed bench for programmable_clock_divider with DEFAULT_DIV overridden to
// 4. Inputs change and outputs are sampled on the falling clock edge. Step
// comments name the rising edge (E<n>) counted from the first enable.
// -----------------------------------------------------------------------------
module tb_programmable_clock_divider;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             en;
  logic             sync_clr;
  logic [WIDTH-1:0] div_in;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] div_active;
  logic             divided_clk;
  logic             tick;
`ifdef CLKDIV_STATUS_EN
  logic [WIDTH-1:0] cnt_out;
  logic [15:0]      wrap_count;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  programmable_clock_divider #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .sync_clr    (sync_clr),
    .div_in      (div_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .div_active  (div_active),
    .divided_clk (divided_clk),
    .tick        (tick)
`ifdef CLKDIV_STATUS_EN
    ,
    .cnt_out     (cnt_out),
    .wrap_count  (wrap_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic enV, input logic clrV,
                               input logic validV, input logic [WIDTH-1:0] divV);
    en         = enV;
    sync_clr   = clrV;
    load_valid = validV;
    div_in     = divV;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_tick",  32'(tick), 32'd0);
    checkOutput("rst_dclk",  32'(divided_clk), 32'd0);
    checkOutput("rst_div",   div_active, 32'd4);
    checkOutput("rst_ready", 32'(load_ready), 32'd1);

    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // D=4: first tick on E5, second on E10
    repeat (4) nextCycle();                               // E4
    checkOutput("a_tick_e4", 32'(tick), 32'd0);
    nextCycle();                                          // E5
    checkOutput("a_tick_e5", 32'(tick), 32'd1);
    checkOutput("a_dclk_e5", 32'(divided_clk), 32'd1);
    nextCycle();                                          // E6
    checkOutput("a_tick_e6", 32'(tick), 32'd0);
    repeat (4) nextCycle();                               // E10
    checkOutput("a_tick_e10", 32'(tick), 32'd1);
    checkOutput("a_dclk_e10", 32'(divided_clk), 32'd0);

    // en low for 7 cycles at cnt=2: next tick moves from E15 to E22
    repeat (2) nextCycle();                               // E12, cnt=2
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 7; i++) begin                     // E13..E19
      nextCycle();
      checkOutput("b_tick_frozen", 32'(tick), 32'd0);
      checkOutput("b_dclk_frozen", 32'(divided_clk), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    repeat (2) nextCycle();                               // E21, cnt=4
    checkOutput("b_tick_e21", 32'(tick), 32'd0);
    nextCycle();                                          // E22
    checkOutput("b_tick_e22", 32'(tick), 32'd1);
    checkOutput("b_dclk_e22", 32'(divided_clk), 32'd1);

    // Load D=2 at cnt=1; current period still ends at cnt=4
    nextCycle();                                          // E23, cnt=1
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd2);
    nextCycle();                                          // E24, accepted
    checkOutput("c_ready_drop", 32'(load_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd2);
    repeat (2) nextCycle();                               // E26, cnt=4
    checkOutput("c_tick_e26", 32'(tick), 32'd0);
    checkOutput("c_div_old", div_active, 32'd4);
    checkOutput("c_ready_pend", 32'(load_ready), 32'd0);
    nextCycle();                                          // E27, wrap+swap
    checkOutput("c_tick_e27", 32'(tick), 32'd1);
    checkOutput("c_dclk_e27", 32'(divided_clk), 32'd0);
    checkOutput("c_div_new", div_active, 32'd2);
    checkOutput("c_ready_back", 32'(load_ready), 32'd1);
    repeat (2) nextCycle();                               // E29
    checkOutput("c_tick_e29", 32'(tick), 32'd0);
    nextCycle();                                          // E30
    checkOutput("c_tick_e30", 32'(tick), 32'd1);
    checkOutput("c_dclk_e30", 32'(divided_clk), 32'd1);

    // Second request while pending is refused; accepted after the wrap
    repeat (3) nextCycle();                               // E33, wrap
    checkOutput("d_tick_e33", 32'(tick), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd3);
    nextCycle();                                          // E34, 3 accepted
    checkOutput("d_ready_e34", 32'(load_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd1);
    nextCycle();                                          // E35, 1 refused
    checkOutput("d_ready_e35", 32'(load_ready), 32'd0);
    checkOutput("d_div_e35", div_active, 32'd2);
    nextCycle();                                          // E36, wrap, swap to 3
    checkOutput("d_tick_e36", 32'(tick), 32'd1);
    checkOutput("d_div_e36", div_active, 32'd3);
    checkOutput("d_ready_e36", 32'(load_ready), 32'd1);
    checkOutput("d_dclk_e36", 32'(divided_clk), 32'd1);
    nextCycle();                                          // E37, 1 accepted
    checkOutput("d_ready_e37", 32'(load_ready), 32'd0);
    checkOutput("d_tick_e37", 32'(tick), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd1);

    // sync_clr at cnt=3 (also a wrap cycle) with D=1 pending
    repeat (2) nextCycle();                               // E39, cnt=3
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1);
    nextCycle();                                          // E40
    checkOutput("e_tick_clr", 32'(tick), 32'd0);
    checkOutput("e_dclk_clr", 32'(divided_clk), 32'd0);
    checkOutput("e_div_clr", div_active, 32'd1);
    checkOutput("e_ready_clr", 32'(load_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd1);
    nextCycle();                                          // E41
    checkOutput("e_tick_e41", 32'(tick), 32'd0);
    nextCycle();                                          // E42
    checkOutput("e_tick_e42", 32'(tick), 32'd1);
    checkOutput("e_dclk_e42", 32'(divided_clk), 32'd1);
    nextCycle();                                          // E43
    checkOutput("e_tick_e43", 32'(tick), 32'd0);
    nextCycle();                                          // E44
    checkOutput("e_tick_e44", 32'(tick), 32'd1);
    checkOutput("e_dclk_e44", 32'(divided_clk), 32'd0);

    // D=0: tick every cycle, divided_clk = clk/2
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
    nextCycle();                                          // E45
    checkOutput("f_tick_e45", 32'(tick), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    nextCycle();                                          // E46, swap to 0
    checkOutput("f_tick_e46", 32'(tick), 32'd1);
    checkOutput("f_dclk_e46", 32'(divided_clk), 32'd1);
    checkOutput("f_div_e46", div_active, 32'd0);
    nextCycle();                                          // E47
    checkOutput("f_tick_e47", 32'(tick), 32'd1);
    checkOutput("f_dclk_e47", 32'(divided_clk), 32'd0);
    nextCycle();                                          // E48
    checkOutput("f_tick_e48", 32'(tick), 32'd1);
    checkOutput("f_dclk_e48", 32'(divided_clk), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd7);
    nextCycle();                                          // E49, 7 pending
    checkOutput("f_tick_e49", 32'(tick), 32'd1);
    checkOutput("f_dclk_e49", 32'(divided_clk), 32'd0);
    checkOutput("f_ready_e49", 32'(load_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd7);

    // Async reset mid-cycle discards the pending load
    #2 reset_n = 1'b0;
    #1;
    checkOutput("g_tick_rst", 32'(tick), 32'd0);
    checkOutput("g_dclk_rst", 32'(divided_clk), 32'd0);
    checkOutput("g_div_rst", div_active, 32'd4);
    checkOutput("g_ready_rst", 32'(load_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) nextCycle();
    checkOutput("g_tick_r4", 32'(tick), 32'd0);
    nextCycle();
    checkOutput("g_tick_r5", 32'(tick), 32'd1);
    checkOutput("g_div_r5", div_active, 32'd4);
    checkOutput("g_dclk_r5", 32'(divided_clk), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/programmable_clock_divider.md
Name: programmable_clock_divider

Overview:
- Runtime-programmable successor to the fixed-ratio clock divider; generates timebase ticks for the wall-clock/alarm datapath (1 Hz seconds tick, display-mux scan, blink rate).
- Divide ratio loaded at run time through a valid/ready handshake and applied glitch-free at the next wrap.
- Provides a 50%-duty toggled output and a one-cycle tick strobe, both registered.
- Adds enable and synchronous phase-clear controls.

Parameters:
- WIDTH, 32, width of counter and divide value.
- DEFAULT_DIV, 100, terminal count loaded into the active divisor at reset.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; low freezes counter and outputs.
- sync_clr  in  1  synchronous phase restart: counter and outputs to zero.
- div_in  in  WIDTH  new terminal count D (output period = D+1 cycles per tick).
- load_valid  in  1  request to load div_in.
- load_ready  out  1  high when no load is pending (= ~pending).
- div_active  out  WIDTH  terminal count currently in use.
- divided_clk  out  1  toggles at every wrap; period 2*(D+1) cycles.
- tick  out  1  one-cycle pulse per wrap; period D+1 cycles.

Behaviour:
- Reset (async, reset_n=0): cnt=0, div_active=DEFAULT_DIV, shadow=0, pending=0, divided_clk=0, tick=0, load_ready=1.
- Priority at each edge: reset_n > sync_clr > counting/load.
- Wrap condition: en=1 and cnt==div_active. On the wrap edge:
  - cnt<=0.
  - tick<=1 for exactly one cycle.
  - divided_clk<=~divided_clk.
  - If pending=1: div_active<=shadow and pending<=0.
- Non-wrap edge with en=1: cnt<=cnt+1; tick<=0.
- en=0: cnt, divided_clk, div_active hold; tick<=0. Load handshake still operates.
- Load handshake:
  - Transfer occurs when load_valid && load_ready: shadow<=div_in, pending<=1.
  - load_valid while pending=1 is not accepted; the requester holds it until ready.
  - A transfer on the same edge as a wrap does not affect that wrap; the new value applies at the following wrap.
- sync_clr=1:
  - cnt<=0, divided_clk<=0, tick<=0.
  - If pending=1, the shadow is applied immediately and pending clears.
  - A load_valid in the same cycle is accepted into the shadow but still pending afterwards.
- D=0: wrap every enabled cycle; tick held high continuously; divided_clk = clk/2.
- A divisor decrease never requires cnt to run past the new value, because the swap happens only at cnt=0.
- Arithmetic is unsigned WIDTH bits. cnt never exceeds div_active, so no overflow path exists.
- Reset asserted mid-period: immediate return to reset values; the pending load is discarded.

Optional Feature:
- Macro CLKDIV_STATUS_EN.
- Defined:
  - Adds output cnt_out[WIDTH] (live counter).
  - Adds output wrap_count[16], incremented on each wrap, wrapping from 0xFFFF to 0, cleared by reset and sync_clr.
  - Used for alarm debug and coverage.
- Undefined: neither port exists and no extra logic is generated.
- Core behaviour is identical in both builds.

Decomposition:
- Shared package clkdiv_pkg:
  - Default WIDTH and DEFAULT_DIV constants.
  - Standard divisors for a 10 MHz system clock: DIV_1HZ=4_999_999 (tick 10 MHz/5e6 = 2 Hz, divided_clk = 1 Hz), DIV_SCAN_1KHZ=9_999.
- Natural sub-module: clkdiv_shadow_reg, holding the shadow register, pending flag and load_ready logic; the top holds the counter and outputs.

Test Plan:
- Reset then en=1, DEFAULT_DIV=4 (override) -> tick every 5 cycles; divided_clk period 10 cycles; first tick 5 edges after en rises.
- Load D=2 while cnt=1 of D=4 -> load_ready drops next cycle; current period finishes at cnt=4; subsequent ticks every 3 cycles; load_ready returns 1 after the swap.
- Second load_valid while pending -> not accepted; shadow unchanged; accepted after the wrap with load_ready=1.
- en low for 7 cycles at cnt=2 -> cnt, divided_clk frozen, tick=0; resumes at cnt=3; tick interval stretched by exactly 7.
- sync_clr at cnt=3 with pending D=1 -> next edge cnt=0, divided_clk=0, div_active=1; ticks every 2 cycles thereafter.
- Load D=0 -> after the swap tick stays 1 every enabled cycle; divided_clk toggles every cycle. Then assert reset_n=0 asynchronously mid-cycle -> all outputs zero immediately; div_active=DEFAULT_DIV.
